// File: rtl/falu_trn_pipe_if.sv
// -----------------------------------------------------------------------------
// falu_trn_pipe_if
//
// Purpose:
//   Issue-side and writeback-side handshake bundle of the FALU transfer/classify
//   pipe. The upstream (issue port) and downstream (writeback arbiter) views are
//   merged into one interface. Each side uses valid/ready.
//
// Parameters:
//   TAG_W      ROB tag width carried alongside each op.
//
// Signals:
//   IN_VALID   op offered by the issue port
//   IN_READY   pipe can accept this cycle
//   IN_OP      transfer sub-op (INT2FP / FP2INT / FCLASS)
//   IN_DOUBLE  1 = double precision, 0 = single
//   IN_DATA    64-bit operand
//   IN_TAG     ROB tag of the op
//   OUT_VALID  result available
//   OUT_READY  writeback arbiter accepts
//   OUT_DATA   64-bit result
//   OUT_TAG    ROB tag of the result
//
// Modports:
//   master  the environment around the pipe (drives IN_*, consumes OUT_*)
//   slave   the pipe itself
// -----------------------------------------------------------------------------
interface falu_trn_pipe_if #(
    parameter int TAG_W = 6
) ();
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       IN_OP;
    logic             IN_DOUBLE;
    logic [63:0]      IN_DATA;
    logic [TAG_W-1:0] IN_TAG;

    logic             OUT_VALID;
    logic             OUT_READY;
    logic [63:0]      OUT_DATA;
    logic [TAG_W-1:0] OUT_TAG;

    modport master (
        output IN_VALID, IN_OP, IN_DOUBLE, IN_DATA, IN_TAG,
        input  IN_READY,
        input  OUT_VALID, OUT_DATA, OUT_TAG,
        output OUT_READY
    );

    modport slave (
        input  IN_VALID, IN_OP, IN_DOUBLE, IN_DATA, IN_TAG,
        output IN_READY,
        output OUT_VALID, OUT_DATA, OUT_TAG,
        input  OUT_READY
    );
endinterface

// File: rtl/falu_trn_pipe.sv
// -----------------------------------------------------------------------------
// falu_trn_pipe
//
// Purpose:
//   FP transfer / classify unit for the FALU execution lane. It covers the
//   FMV/FCLASS class of operations. The result is formed combinationally at
//   accept time. It then travels through an elastic valid/ready pipeline of
//   STAGES registers together with its ROB tag. Ordering is strict FIFO and
//   throughput is one op per cycle while OUT_READY stays high. There is no
//   skid buffer, so IN_READY is combinational from OUT_READY.
//
// Parameters:
//   FLEN     FP register width, 32 or 64. With 32, IN_DOUBLE is ignored.
//   STAGES   register stages, 1..4, which is also the result latency.
//   TAG_W    ROB tag width. It must match the TAG_W of the interface.
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset (clears valids, data and tags)
//   FLUSH    synchronous kill of every in-flight op. An op offered in the
//            same cycle is dropped.
//   bus      falu_trn_pipe_if.slave (IN_* issue side, OUT_* writeback side)
//
// Sub-op encoding (IN_OP):
//   3'd0 INT2FP, 3'd1 FP2INT, 3'd2 FCLASS. Every other code retires with 0.
//
// Optional feature:
//   `define FALU_TRN_NANBOX_CHECK_EN
//     Enables the NaN-box check on single-precision FCLASS / FP2INT operands
//     when FLEN = 64. An operand whose upper word is not all-ones is replaced
//     by the canonical qNaN 32'h7FC00000.
// -----------------------------------------------------------------------------
module falu_trn_pipe #(
    parameter int FLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FLUSH,
    falu_trn_pipe_if.slave      bus
);

    localparam logic [2:0] SUBOP_TRN_INT2FP = 3'd0;
    localparam logic [2:0] SUBOP_TRN_FP2INT = 3'd1;
    localparam logic [2:0] SUBOP_TRN_FCLASS = 3'd2;

    localparam logic [31:0] CANON_QNAN_S = 32'h7FC0_0000;
    localparam bit          HAS_DOUBLE   = (FLEN == 64);

    // -------------------------------------------------------------------------
    // Classification. The caller supplies decoded exponent/mantissa flags so
    // that one function serves both precisions.
    // -------------------------------------------------------------------------
    function automatic logic [9:0] classify(
        input logic sign,
        input logic exp_ones,
        input logic exp_zero,
        input logic man_zero,
        input logic man_msb
    );
        logic [9:0] cls;
        cls = '0;
        if (exp_ones) begin
            if (man_zero)     cls[sign ? 0 : 7] = 1'b1;  // infinity
            else if (man_msb) cls[9] = 1'b1;             // quiet NaN
            else              cls[8] = 1'b1;             // signalling NaN
        end else if (exp_zero) begin
            if (man_zero)     cls[sign ? 3 : 4] = 1'b1;  // zero
            else              cls[sign ? 2 : 5] = 1'b1;  // subnormal
        end else begin
            cls[sign ? 1 : 6] = 1'b1;                    // normal
        end
        return cls;
    endfunction

    // -------------------------------------------------------------------------
    // Result formation (combinational, at accept time)
    // -------------------------------------------------------------------------
    logic        is_double;
    logic [31:0] opnd_s;
    logic [63:0] opnd_d;
    logic [9:0]  class_s;
    logic [9:0]  class_d;
    logic [63:0] result;

    assign is_double = HAS_DOUBLE && bus.IN_DOUBLE;
    assign opnd_d    = bus.IN_DATA;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        opnd_s = bus.IN_DATA[31:0];
`ifdef FALU_TRN_NANBOX_CHECK_EN
        // Only a correctly NaN-boxed single is trusted. Anything else reads
        // as the canonical quiet NaN.
        if (HAS_DOUBLE && !is_double &&
            (bus.IN_OP == SUBOP_TRN_FCLASS || bus.IN_OP == SUBOP_TRN_FP2INT) &&
            bus.IN_DATA[63:32] != 32'hFFFF_FFFF) begin
            opnd_s = CANON_QNAN_S;
        end
`endif
    end

    assign class_s = classify(opnd_s[31],
                              &opnd_s[30:23],
                              ~|opnd_s[30:23],
                              ~|opnd_s[22:0],
                              opnd_s[22]);

    assign class_d = classify(opnd_d[63],
                              &opnd_d[62:52],
                              ~|opnd_d[62:52],
                              ~|opnd_d[51:0],
                              opnd_d[51]);

    always_comb begin
        result = '0;
        unique case (bus.IN_OP)
            SUBOP_TRN_INT2FP:
                result = is_double ? opnd_d : {32'hFFFF_FFFF, bus.IN_DATA[31:0]};
            SUBOP_TRN_FP2INT:
                result = is_double ? opnd_d : {{32{opnd_s[31]}}, opnd_s};
            SUBOP_TRN_FCLASS:
                result = {54'd0, (is_double ? class_d : class_s)};
            default:
                result = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Elastic pipeline. Stage 0 receives accepted ops and stage STAGES-1 drives
    // the output. Stage i loads when some stage at or after i is empty, or when
    // the output drains. This closed form avoids a combinational chain through
    // the load vector itself.
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [63:0]       data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_valid;
    logic [63:0]       src_data [STAGES];
    logic [TAG_W-1:0]  src_tag  [STAGES];
    logic              accept;

    always_comb begin
        logic tail_full;
        load = '0;
        for (int i = 0; i < STAGES; i++) begin
            tail_full = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                tail_full = tail_full & valid_q[j];
            end
            load[i] = bus.OUT_READY | ~tail_full;
        end
    end

    // FLUSH forces IN_READY so the issue port never stalls on a dying pipe.
    // The op it offers is still dropped, because accept excludes FLUSH.
    assign bus.IN_READY = FLUSH | load[0];
    assign accept       = bus.IN_VALID & load[0] & ~FLUSH;

    // Source of each stage: the new op for stage 0, the previous stage for
    // every other stage.
    always_comb begin
        src_valid   = '0;
        src_valid[0] = accept;
        src_data[0]  = result;
        src_tag[0]   = bus.IN_TAG;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
            src_tag[i]   = tag_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // stage samples its source's value from before this edge.
        if (RST) begin
            // NOTE: data and tag registers are reset too, so OUT_DATA and
            // OUT_TAG read 0 straight after reset rather than holding stale bits.
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (FLUSH) begin
            // Only the valids die. The payload is left as it is.
            valid_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_q[i] <= src_valid[i];
                    // Payload moves only with a real op, so bubbles do not toggle it.
                    if (src_valid[i]) begin
                        data_q[i] <= src_data[i];
                        tag_q[i]  <= src_tag[i];
                    end
                end
            end
        end
    end

    assign bus.OUT_VALID = valid_q[STAGES-1];
    assign bus.OUT_DATA  = data_q[STAGES-1];
    assign bus.OUT_TAG   = tag_q[STAGES-1];

endmodule

// File: tb/tb_falu_trn_pipe.sv
// -----------------------------------------------------------------------------
// tb_falu_trn_pipe
//
// Directed bench for falu_trn_pipe with default parameters (FLEN=64,
// STAGES=2, TAG_W=6). Expected values are hand-computed constants. The stream
// section uses a small occupancy model. When FALU_TRN_NANBOX_CHECK_EN is
// defined, the expectations that depend on it switch with it.
// -----------------------------------------------------------------------------
module tb_falu_trn_pipe;

    localparam int STAGES = 2;
    localparam int TAG_W  = 6;

    localparam logic [2:0] OP_INT2FP = 3'd0;
    localparam logic [2:0] OP_FP2INT = 3'd1;
    localparam logic [2:0] OP_FCLASS = 3'd2;
    localparam logic [2:0] OP_UNUSED = 3'b111;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic FLUSH = 1'b0;

    falu_trn_pipe_if #(.TAG_W(TAG_W)) bus ();

    falu_trn_pipe #(
        .FLEN   (64),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .FLUSH (FLUSH),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // On entry and on exit the time is 1 after a rising edge.
    task automatic run_one(input string name, input logic [2:0] op, input logic dbl,
                           input logic [63:0] d, input logic [5:0] tag,
                           input logic [63:0] exp);
        int edges;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.IN_OP     = op;
        bus.IN_DOUBLE = dbl;
        bus.IN_DATA   = d;
        bus.IN_TAG    = tag;
        #1;
        check({name, " in_ready"}, 64'(bus.IN_READY), 64'd1);
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        edges = 1;
        while (!bus.OUT_VALID && edges < 20) begin
            @(posedge CLK); #1;
            edges++;
        end
        check({name, " latency"}, 64'(edges), 64'(STAGES));
        check({name, " data"}, bus.OUT_DATA, exp);
        check({name, " tag"}, 64'(bus.OUT_TAG), 64'(tag));
        @(posedge CLK); #1;
        check({name, " drained"}, 64'(bus.OUT_VALID), 64'd0);
    endtask

    // Push n ops into a stalled pipe (OUT_READY = 0).
    task automatic fill_stalled(input int n, input logic [5:0] base_tag);
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_OP     = OP_INT2FP;
            bus.IN_DOUBLE = 1'b1;
            bus.IN_DATA   = 64'hC0DE_0000_0000_0000 | 64'(i);
            bus.IN_TAG    = base_tag + 6'(i);
            @(posedge CLK); #1;
        end
        bus.IN_VALID = 1'b0;
    endtask

    function automatic logic [63:0] stream_data(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i * 32'h1111);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent, recv, occ, cyc;
        logic in_fire, out_fire, prev_hold, saw_full;
        logic [63:0] prev_d;
        logic [5:0]  prev_t;

        bus.IN_VALID  = 1'b0;
        bus.IN_OP     = '0;
        bus.IN_DOUBLE = 1'b0;
        bus.IN_DATA   = '0;
        bus.IN_TAG    = '0;
        bus.OUT_READY = 1'b1;

        // ---------------- reset ----------------
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("reset out_valid", 64'(bus.OUT_VALID), 64'd0);
        check("reset out_data",  bus.OUT_DATA, 64'd0);
        check("reset out_tag",   64'(bus.OUT_TAG), 64'd0);
        check("reset in_ready",  64'(bus.IN_READY), 64'd1);
        @(posedge CLK); #1;

        // ---------------- directed single ops ----------------
        run_one("fclass d +inf",  OP_FCLASS, 1'b1, 64'h7FF0_0000_0000_0000, 6'd1, 64'h080);
`ifdef FALU_TRN_NANBOX_CHECK_EN
        run_one("fclass s unboxed", OP_FCLASS, 1'b0, 64'h0000_0000_3F80_0000, 6'd2, 64'h200);
        run_one("fp2int s unboxed", OP_FP2INT, 1'b0, 64'h0000_0000_3F80_0000, 6'd3, 64'h0000_0000_7FC0_0000);
`else
        run_one("fclass s unboxed", OP_FCLASS, 1'b0, 64'h0000_0000_3F80_0000, 6'd2, 64'h040);
        run_one("fp2int s unboxed", OP_FP2INT, 1'b0, 64'h0000_0000_3F80_0000, 6'd3, 64'h0000_0000_3F80_0000);
`endif
        run_one("fclass s +sub",  OP_FCLASS, 1'b0, 64'hFFFF_FFFF_0000_0001, 6'd4, 64'h020);
        run_one("int2fp s",       OP_INT2FP, 1'b0, 64'h1234_5678_3F80_0000, 6'd5, 64'hFFFF_FFFF_3F80_0000);
        run_one("fp2int s neg",   OP_FP2INT, 1'b0, 64'hFFFF_FFFF_BF80_0000, 6'd6, 64'hFFFF_FFFF_BF80_0000);
        run_one("fp2int s pos",   OP_FP2INT, 1'b0, 64'hFFFF_FFFF_7F00_0000, 6'd7, 64'h0000_0000_7F00_0000);
        run_one("unused op",      OP_UNUSED, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 6'd8, 64'h0);
        run_one("int2fp d",       OP_INT2FP, 1'b1, 64'h1234_5678_9ABC_DEF0, 6'd9, 64'h1234_5678_9ABC_DEF0);
        run_one("fp2int d",       OP_FP2INT, 1'b1, 64'hFEDC_BA98_7654_3210, 6'd10, 64'hFEDC_BA98_7654_3210);
        run_one("fclass d -inf",  OP_FCLASS, 1'b1, 64'hFFF0_0000_0000_0000, 6'd11, 64'h001);
        run_one("fclass d -0",    OP_FCLASS, 1'b1, 64'h8000_0000_0000_0000, 6'd12, 64'h008);
        run_one("fclass d qnan",  OP_FCLASS, 1'b1, 64'h7FF8_0000_0000_0000, 6'd13, 64'h200);
        run_one("fclass d snan",  OP_FCLASS, 1'b1, 64'h7FF0_0000_0000_0001, 6'd14, 64'h100);
        run_one("fclass d +norm", OP_FCLASS, 1'b1, 64'h3FF0_0000_0000_0000, 6'd15, 64'h040);
        run_one("fclass s -sub",  OP_FCLASS, 1'b0, 64'hFFFF_FFFF_807F_FFFF, 6'd16, 64'h004);
        run_one("fclass s +0",    OP_FCLASS, 1'b0, 64'hFFFF_FFFF_0000_0000, 6'd17, 64'h010);
        run_one("fclass s -norm", OP_FCLASS, 1'b0, 64'hFFFF_FFFF_C000_0000, 6'd18, 64'h002);

        // ---------------- stream with mid-stream stall ----------------
        sent = 0; recv = 0; occ = 0; cyc = 0;
        prev_hold = 1'b0; saw_full = 1'b0;
        prev_d = '0; prev_t = '0;
        while (recv < 10 && cyc < 100) begin
            bus.IN_VALID  = (sent < 10);
            bus.IN_OP     = OP_INT2FP;
            bus.IN_DOUBLE = 1'b1;
            bus.IN_DATA   = stream_data(sent);
            bus.IN_TAG    = 6'(sent);
            bus.OUT_READY = !(cyc >= 4 && cyc <= 8);
            #1;
            check("stream in_ready", 64'(bus.IN_READY), 64'((occ < STAGES) || bus.OUT_READY));
            if (!bus.IN_READY) saw_full = 1'b1;
            if (prev_hold) begin
                check("stall data stable", bus.OUT_DATA, prev_d);
                check("stall tag stable",  64'(bus.OUT_TAG), 64'(prev_t));
            end
            in_fire  = bus.IN_VALID & bus.IN_READY;
            out_fire = bus.OUT_VALID & bus.OUT_READY;
            if (out_fire) begin
                check("stream tag",  64'(bus.OUT_TAG), 64'(recv));
                check("stream data", bus.OUT_DATA, stream_data(recv));
            end
            prev_hold = bus.OUT_VALID & ~bus.OUT_READY;
            prev_d    = bus.OUT_DATA;
            prev_t    = bus.OUT_TAG;
            @(posedge CLK); #1;
            if (in_fire)  begin sent++; occ++; end
            if (out_fire) begin recv++; occ--; end
            cyc++;
        end
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        check("stream all received", 64'(recv), 64'd10);
        check("stream in_ready dropped", 64'(saw_full), 64'd1);
        #1;
        check("stream no extra", 64'(bus.OUT_VALID), 64'd0);
        @(posedge CLK); #1;

        // ---------------- flush with a full pipe ----------------
        fill_stalled(STAGES, 6'd20);
        check("full in_ready", 64'(bus.IN_READY), 64'd0);
        check("full out_valid", 64'(bus.OUT_VALID), 64'd1);
        FLUSH         = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.IN_OP     = OP_INT2FP;
        bus.IN_DOUBLE = 1'b1;
        bus.IN_DATA   = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.IN_TAG    = 6'd30;
        #1;
        check("flush in_ready", 64'(bus.IN_READY), 64'd1);
        @(posedge CLK); #1;
        FLUSH         = 1'b0;
        bus.IN_VALID  = 1'b0;
        check("flush out_valid", 64'(bus.OUT_VALID), 64'd0);
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) begin
            @(posedge CLK); #1;
            check("flushed op absent", 64'(bus.OUT_VALID), 64'd0);
        end
        run_one("post-flush op", OP_FCLASS, 1'b1, 64'hBFF0_0000_0000_0000, 6'd31, 64'h002);

        // ---------------- reset with a full, stalled pipe ----------------
        fill_stalled(STAGES, 6'd40);
        check("pre-reset out_valid", 64'(bus.OUT_VALID), 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst out_valid", 64'(bus.OUT_VALID), 64'd0);
        check("rst out_data",  bus.OUT_DATA, 64'd0);
        check("rst out_tag",   64'(bus.OUT_TAG), 64'd0);
        check("rst in_ready",  64'(bus.IN_READY), 64'd1);
        RST = 1'b0;
        @(posedge CLK); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
